// File: rtl/pla_timer_compare_pkg.sv
// Shared constants and types for the alarm-compare sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pla_timer_compare_pkg;

   // Shared state-bus codes owned by this controller (0x8-0xF) plus global idle
   localparam logic [3:0] ST_IDLE  = 4'h0;
   localparam logic [3:0] ST_INIT  = 4'h8;
   localparam logic [3:0] ST_LDA   = 4'h9;
   localparam logic [3:0] ST_LDB   = 4'hA;
   localparam logic [3:0] ST_CMP   = 4'hB;
   localparam logic [3:0] ST_TEST  = 4'hC;
   localparam logic [3:0] ST_NEXT  = 4'hD;
   localparam logic [3:0] ST_MATCH = 4'hE;
   localparam logic [3:0] ST_DONE  = 4'hF;

   // ALU operation select; 2'b11 is reserved and never issued
   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_PASS = 2'b01,
      ALU_SUB  = 2'b10
   } alu_sel_e;

   // Control word driven onto the shared control bus
   typedef struct packed {
      logic     Kc;
      logic     La;
      logic     Lb;
      logic     Ea;
      logic     Lr;
      logic     Er;
      logic     Cc;
      logic     M;
      alu_sel_e s;
   } ctl_t;

endpackage

// File: rtl/pla_timer_compare_pla_logic.sv
// Combinational decode of (shared code, flags) into next code, step one-hot and controls.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; foreign or idle codes decode to all-zero controls.
module tc_pla_logic
   import pla_timer_compare_pkg::*;
(
   input  logic [3:0] gin_i,
   input  logic       ts_i,
   input  logic       c7_i,
   input  logic       az_i,
   output logic [3:0] gout_o,
   output logic [9:0] t_o,
   output ctl_t       ctl_o
);

   // Step decode: flags only matter in the step that consumes them
   always_comb begin
      gout_o = ST_IDLE;
      t_o    = '0;
      ctl_o  = '0;
      case (gin_i)
         ST_IDLE: begin
            gout_o = ts_i ? ST_INIT : ST_IDLE;
         end
         ST_INIT: begin
            t_o[0]   = 1'b1;
            ctl_o.Kc = 1'b1;
            gout_o   = ST_LDA;
         end
         ST_LDA: begin
            t_o[1]   = 1'b1;
            ctl_o.La = 1'b1;
            gout_o   = ST_LDB;
         end
         ST_LDB: begin
            t_o[2]   = 1'b1;
            ctl_o.Lb = 1'b1;
            gout_o   = ST_CMP;
         end
         ST_CMP: begin
            t_o[3]   = 1'b1;
            ctl_o.Ea = 1'b1;
            ctl_o.Lr = 1'b1;
            ctl_o.s  = ALU_SUB;
            gout_o   = ST_TEST;
         end
         ST_TEST: begin
            t_o[4] = 1'b1;
            gout_o = az_i ? ST_NEXT : ST_DONE;
         end
         ST_NEXT: begin
            t_o[5]   = 1'b1;
            ctl_o.Cc = 1'b1;
            gout_o   = c7_i ? ST_MATCH : ST_LDA;
         end
         ST_MATCH: begin
            t_o[6]   = 1'b1;
            ctl_o.M  = 1'b1;
            ctl_o.Er = 1'b1;
            gout_o   = ST_DONE;
         end
         ST_DONE: begin
            t_o[7] = 1'b1;
            gout_o = ST_IDLE;
         end
         default: begin
            // Codes 0x1-0x7 belong to other controllers: stay silent on the OR bus
            gout_o = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/pla_timer_compare.sv
// Alarm compare sequencer on the shared state/control bus; optional TIMER_COMPARE_STICKY_MATCH_EN holds M until Ts drops.
// Latency: every output registered, one clk edge after the gin value that produced it.
// Backpressure: none; sequence free-runs once started, reset aborts at any step.
module pla_timer_compare
   import pla_timer_compare_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] gin,
   input  logic       Ts,
   input  logic       c7,
   input  logic       Az,
   output logic [3:0] gout,
   output logic [9:0] T,
   output logic [1:0] s,
   output logic       Kc,
   output logic       La,
   output logic       Lb,
   output logic       Ea,
   output logic       Lr,
   output logic       Er,
   output logic       Cc,
   output logic       M
);

   logic [3:0] gout_d, gout_q;
   logic [9:0] t_d, t_q;
   ctl_t       pla_ctl;
   ctl_t       ctl_d, ctl_q;

   tc_pla_logic u_pla (
      .gin_i  (gin),
      .ts_i   (Ts),
      .c7_i   (c7),
      .az_i   (Az),
      .gout_o (gout_d),
      .t_o    (t_d),
      .ctl_o  (pla_ctl)
   );

   // Match output shaping: pulse by default, latched until Ts drops when sticky
   always_comb begin
      ctl_d = pla_ctl;
`ifdef TIMER_COMPARE_STICKY_MATCH_EN
      ctl_d.M = pla_ctl.M | (ctl_q.M & Ts);
`else
      ctl_d.M = pla_ctl.M;
`endif
   end

   // Output registers with synchronous reset overriding any step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gout_q <= ST_IDLE;
         t_q    <= '0;
         ctl_q  <= '0;
      end else begin
         gout_q <= gout_d;
         t_q    <= t_d;
         ctl_q  <= ctl_d;
      end
   end

   assign gout = gout_q;
   assign T    = t_q;
   assign s    = ctl_q.s;
   assign Kc   = ctl_q.Kc;
   assign La   = ctl_q.La;
   assign Lb   = ctl_q.Lb;
   assign Ea   = ctl_q.Ea;
   assign Lr   = ctl_q.Lr;
   assign Er   = ctl_q.Er;
   assign Cc   = ctl_q.Cc;
   assign M    = ctl_q.M;

endmodule

// File: tb/tb_pla_timer_compare.sv
// Self-checking bench for pla_timer_compare using an expected-output queue.
// Latency: checks each output one edge after its stimulus.
// Backpressure: n/a.
module tb_pla_timer_compare;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] gin = 4'h0;
   logic       Ts = 1'b0;
   logic       c7 = 1'b0;
   logic       Az = 1'b0;
   logic [3:0] gout;
   logic [9:0] T;
   logic [1:0] s;
   logic       Kc, La, Lb, Ea, Lr, Er, Cc, M;

   int checks = 0;
   int errors = 0;
   logic m_hold = 1'b0;
   logic [23:0] sb[$];
   logic [23:0] obs;

   pla_timer_compare dut (
      .clk(clk), .rst_n(rst_n), .gin(gin), .Ts(Ts), .c7(c7), .Az(Az),
      .gout(gout), .T(T), .s(s), .Kc(Kc), .La(La), .Lb(Lb), .Ea(Ea),
      .Lr(Lr), .Er(Er), .Cc(Cc), .M(M)
   );

   always #5 clk = ~clk;

   assign obs = {gout, T, s, Kc, La, Lb, Ea, Lr, Er, Cc, M};

   // Reference table of the step sequence: {gout, T, s, Kc, La, Lb, Ea, Lr, Er, Cc, M}
   function automatic logic [23:0] model(input logic r, input logic [3:0] g,
                                         input logic ts, input logic c7i,
                                         input logic azi, input logic mh);
      logic [3:0] nx = 4'h0;
      logic [9:0] t = '0;
      logic [1:0] sel = 2'b00;
      logic kc = 0, la = 0, lb = 0, ea = 0, lr = 0, er = 0, cc = 0, m = 0;
      if (r) begin
         case (g)
            4'h0: nx = ts ? 4'h8 : 4'h0;
            4'h8: begin t[0] = 1; kc = 1; nx = 4'h9; end
            4'h9: begin t[1] = 1; la = 1; nx = 4'hA; end
            4'hA: begin t[2] = 1; lb = 1; nx = 4'hB; end
            4'hB: begin t[3] = 1; ea = 1; lr = 1; sel = 2'b10; nx = 4'hC; end
            4'hC: begin t[4] = 1; nx = azi ? 4'hD : 4'hF; end
            4'hD: begin t[5] = 1; cc = 1; nx = c7i ? 4'hE : 4'h9; end
            4'hE: begin t[6] = 1; m = 1; er = 1; nx = 4'hF; end
            4'hF: begin t[7] = 1; nx = 4'h0; end
            default: nx = 4'h0;
         endcase
`ifdef TIMER_COMPARE_STICKY_MATCH_EN
         m = m | (mh & ts);
`endif
      end
      return {nx, t, sel, kc, la, lb, ea, lr, er, cc, m};
   endfunction

   // Drive one cycle of stimulus, queue its expected outputs, sample after the edge
   task automatic apply(input logic r, input logic [3:0] g, input logic ts,
                        input logic c7i, input logic azi);
      logic [23:0] e;
      rst_n = r; gin = g; Ts = ts; c7 = c7i; Az = azi;
      e = model(r, g, ts, c7i, azi, m_hold);
      m_hold = e[0];
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [23:0] e;
      apply(1'b0, 4'hB, 1'b1, 1'b1, 1'b1);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_vec got %h want %h", obs, e); end
      checks++;
      if (obs !== 24'h0) begin errors++; $display("FAIL reset_zero got %h want 000000", obs); end
      // Reset in the middle of a compare step
      apply(1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_pre got %h want %h", obs, e); end
      apply(1'b0, 4'hC, 1'b1, 1'b0, 1'b1);
      e = sb.pop_front(); checks++;
      if (obs !== 24'h0) begin errors++; $display("FAIL reset_mid got %h want 000000", obs); end
   endtask

   task automatic test_idle();
      logic [23:0] e;
      apply(1'b1, 4'h0, 1'b0, 1'b1, 1'b1);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL idle_ts0 got %h want %h", obs, e); end
      apply(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL idle_ts1 got %h want %h", obs, e); end
      checks++;
      if (gout !== 4'h8 || T !== 10'd0 || Kc !== 1'b0)
         begin errors++; $display("FAIL idle_start gout %h T %h Kc %b want 8 000 0", gout, T, Kc); end
   endtask

   task automatic test_foreign();
      logic [23:0] e;
      for (int g = 1; g < 8; g++) begin
         apply(1'b1, 4'(g), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         e = sb.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL foreign_%0d got %h want %h", g, obs, e); end
      end
   endtask

   task automatic test_cmp_decode();
      logic [23:0] e;
      apply(1'b1, 4'hB, 1'b0, 1'b1, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL cmp_vec got %h want %h", obs, e); end
      checks++;
      if (T !== 10'b0000001000 || s !== 2'b10 || Ea !== 1'b1 || Lr !== 1'b1 || gout !== 4'hC)
         begin errors++; $display("FAIL cmp_fields T %b s %b Ea %b Lr %b gout %h", T, s, Ea, Lr, gout); end
   endtask

   task automatic test_full_match();
      logic [23:0] e;
      logic [3:0]  g;
      int kc_cnt = 0, cc_cnt = 0, digit = 0, cycles = 0;
      bit saw_match = 0;
      apply(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL full_start got %h want %h", obs, e); end
      g = e[23:20];
      cycles = 1;
      while (g != 4'h0 && cycles < 100) begin
         apply(1'b1, g, 1'b1, (digit == 7), 1'b1);
         e = sb.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL full_step code %h got %h want %h", g, obs, e); end
         if (Kc === 1'b1) kc_cnt++;
         if (Cc === 1'b1) cc_cnt++;
         if (g == 4'hD) digit++;
         if (g == 4'hE) begin
            saw_match = 1;
            checks++;
            if (M !== 1'b1 || Er !== 1'b1 || gout !== 4'hF)
               begin errors++; $display("FAIL full_match M %b Er %b gout %h want 1 1 f", M, Er, gout); end
         end
         g = e[23:20];
         cycles++;
      end
      checks++;
      if (cycles != 44) begin errors++; $display("FAIL full_cycles got %0d want 44", cycles); end
      checks++;
      if (kc_cnt != 1 || cc_cnt != 8)
         begin errors++; $display("FAIL full_pulses Kc %0d Cc %0d want 1 8", kc_cnt, cc_cnt); end
      checks++;
      if (!saw_match) begin errors++; $display("FAIL full_reached_match got 0 want 1"); end
      // After DONE: M held while Ts stays high only in the sticky build
      apply(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
`ifdef TIMER_COMPARE_STICKY_MATCH_EN
      if (M !== 1'b1) begin errors++; $display("FAIL sticky_hold M %b want 1", M); end
`else
      if (M !== 1'b0) begin errors++; $display("FAIL pulse_after M %b want 0", M); end
`endif
      apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); checks++;
      if (obs !== e || M !== 1'b0) begin errors++; $display("FAIL match_release got %h want %h", obs, e); end
   endtask

   task automatic test_mismatch();
      logic [23:0] e;
      logic [3:0]  seq[6] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};
      bit m_seen = 0;
      // Ts dropped mid-sequence must not abort
      for (int i = 0; i < 6; i++) begin
         apply(1'b1, seq[i], (i < 2), 1'b1, 1'b0);
         e = sb.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL mismatch_step %h got %h want %h", seq[i], obs, e); end
         if (M === 1'b1) m_seen = 1;
         if (seq[i] == 4'hC) begin
            checks++;
            if (gout !== 4'hF) begin errors++; $display("FAIL mismatch_abort gout %h want f", gout); end
         end
      end
      checks++;
      if (gout !== 4'h0 || m_seen) begin errors++; $display("FAIL mismatch_end gout %h M_seen %0d want 0 0", gout, m_seen); end
   endtask

   task automatic test_back_to_back();
      logic [23:0] e;
      logic [3:0]  g;
      for (int i = 0; i < 300; i++) begin
         g = 4'($urandom_range(0, 15));
         apply(($urandom_range(0, 15) != 0), g, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         e = sb.pop_front(); checks++;
         if (obs !== e) begin errors++; $display("FAIL random_%0d code %h got %h want %h", i, g, obs, e); end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_foreign();
      test_cmp_decode();
      test_full_match();
      test_mismatch();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
